// File: rtl/wakeup_arbiter_pkg.sv
// Shared definitions for the PMU wake-up arbiter: FSM encoding, priority
// level bounds, channel limit and the source-index width helper.
package wakeup_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_SLEEP = 2'b01,
        ST_REQ   = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] PRIO_MIN = 2'd0;
    localparam logic [1:0] PRIO_MAX = 2'd3;
    localparam int         MAX_NCH  = 8;

    function automatic int sw_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wakeup_arbiter_if.sv
// PMU-side bundle of the wake-up arbiter: the wake request/acknowledge pair
// and the winning-source report delivered when the handshake completes.
interface wakeup_arbiter_if
    import wakeup_arbiter_pkg::*;
#(
    parameter int NCH = 2
);
    localparam int SW = sw_of(NCH);

    // pmuintreq is a held request: once raised it stays high until the PMU
    // answers with pmuack; pmuack while pmuintreq is low has no effect.
    // wake_valid pulses for one cycle after the acknowledge, qualifying
    // wake_src/wake_ext, which stay stable until the next request.
    logic          pmuintreq;
    logic          pmuack;
    logic [SW-1:0] wake_src;
    logic          wake_ext;
    logic          wake_valid;

    modport master (
        output pmuintreq, wake_src, wake_ext, wake_valid,
        input  pmuack
    );

    modport slave (
        input  pmuintreq, wake_src, wake_ext, wake_valid,
        output pmuack
    );

endinterface

// File: rtl/wakeup_chan.sv
// One external interrupt channel: synchroniser, optional glitch filter
// (WAKEUP_GLITCH_FILTER_EN), falling-edge detect and the pending flag.
module wakeup_chan #(
    parameter int SYNC_STAGES = 2
`ifdef WAKEUP_GLITCH_FILTER_EN
    , parameter int FILT_LEN  = 4
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic extint,
    input  logic it,
    input  logic pend_clr,
    output logic pend
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_raw;
    logic                   s;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= extint;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s_raw = sync_q[SYNC_STAGES-1];

`ifdef WAKEUP_GLITCH_FILTER_EN
    logic [3:0] filt_cnt;
    logic       filt_q;

    // The output flips on the FILT_LEN-th consecutive disagreeing sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= '0;
            filt_q   <= 1'b1;
        end else if (s_raw != filt_q) begin
            if (filt_cnt == 4'(FILT_LEN - 1)) begin
                filt_q   <= s_raw;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 4'd1;
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    assign s = filt_q;
`else
    assign s = s_raw;
`endif

    // Edge mode latches until cleared, a coincident set beats the clear;
    // level mode simply mirrors the (active-low) pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
            pend   <= 1'b0;
        end else begin
            prev_q <= s;
            if (it) begin
                pend <= (pend & ~pend_clr) | (prev_q & ~s);
            end else begin
                pend <= ~s;
            end
        end
    end

endmodule

// File: rtl/wakeup_arbiter.sv
// PMU wake-up arbiter: per-channel pending logic, priority masking against
// the in-service levels, winner select and the sleep/request/ack FSM.
// Optional glitch filter enabled with `define WAKEUP_GLITCH_FILTER_EN.
module wakeup_arbiter
    import wakeup_arbiter_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   extint,
    input  logic [NCH-1:0]   it,
    input  logic [NCH-1:0]   eint,
    input  logic             eal,
    input  logic [NCH-1:0]   intprior0,
    input  logic [NCH-1:0]   intprior1,
    input  logic [3:0]       isreg,
    input  logic             irq,
    input  logic             sleep,
    input  logic [NCH-1:0]   pend_clr,
    output logic [NCH-1:0]   pend,
    wakeup_arbiter_if.master pmu,
    output state_t           fsm_state
);

    localparam int SW = sw_of(NCH);

    if (NCH < 1 || NCH > MAX_NCH || SYNC_STAGES < 1 || FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_cfg
        $error("wakeup_arbiter: parameter out of range");
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        wakeup_chan #(
            .SYNC_STAGES (SYNC_STAGES)
`ifdef WAKEUP_GLITCH_FILTER_EN
            , .FILT_LEN  (FILT_LEN)
`endif
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .extint   (extint[gi]),
            .it       (it[gi]),
            .pend_clr (pend_clr[gi]),
            .pend     (pend[gi])
        );
    end

    logic [NCH-1:0] eligible;
    logic [1:0]     cur_lvl;
    logic [1:0]     win_lvl;
    logic [SW-1:0]  win_idx;
    logic           win_found;
    logic           wake;

    // Level L is blocked by any in-service level at or above L; strict '>'
    // keeps the lowest index on equal levels.
    always_comb begin
        eligible  = '0;
        cur_lvl   = PRIO_MIN;
        win_lvl   = PRIO_MIN;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            cur_lvl     = {intprior1[i], intprior0[i]};
            eligible[i] = eal & eint[i] & pend[i] & ((isreg >> cur_lvl) == 4'd0);
            if (eligible[i] && (!win_found || cur_lvl > win_lvl)) begin
                win_found = 1'b1;
                win_lvl   = cur_lvl;
                win_idx   = SW'(i);
            end
        end
    end

    assign wake = irq | (|eligible);

    state_t        state;
    logic [SW-1:0] wake_src_q;
    logic          wake_ext_q;
    logic          wake_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            wake_src_q   <= '0;
            wake_ext_q   <= 1'b0;
            wake_valid_q <= 1'b0;
        end else begin
            wake_valid_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (sleep) state <= ST_SLEEP;
                end
                ST_SLEEP: begin
                    if (wake) begin
                        state      <= ST_REQ;
                        wake_src_q <= win_idx;
                        wake_ext_q <= win_found;
                    end else if (!sleep) begin
                        state <= ST_RUN;
                    end
                end
                ST_REQ: begin
                    if (pmu.pmuack) begin
                        state        <= ST_DONE;
                        wake_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign pmu.pmuintreq  = (state == ST_REQ);
    assign pmu.wake_src   = wake_src_q;
    assign pmu.wake_ext   = wake_ext_q;
    assign pmu.wake_valid = wake_valid_q;
    assign fsm_state      = state;

endmodule
